mc_shift_unit: RTL and testbench
================================

Name: mc_shift_unit

Overview:
- Multi-cycle iterative shifter for the MIPS execute stage; serves SLL/SRL/SRA and rotate-right.
- Complements the combinational fixed left-by-2 branch-offset path with general variable-amount shifting in both directions, mainly right shifts.
- Trades latency for area: shifts STEP bits per cycle under a start/busy/done handshake, so the ALU stalls the pipeline while busy.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; log2(WIDTH)
STEP, 1, max bits shifted per cycle; legal values 1, 2, 4

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE
op  input  2  00 SLL, 10 SRL, 11 SRA, 01 ROR (rotate right); sampled with start
shamt  input  SHAMT_W  shift amount, sampled with start
operand  input  WIDTH  data to shift, sampled with start
kill  input  1  synchronous abort (pipeline flush)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  shifted value, registered, held until the next completion

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, result=0; internal data and count registers cleared.
- Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, capture operand, op and shamt into working registers; cnt=shamt.
  - Next state is SHIFT if shamt!=0, otherwise DONE.
  - start with kill=1 in the same cycle: kill wins, nothing is captured.
- SHIFT, each edge:
  - s=min(STEP,cnt).
  - Working register shifts by s according to op:
    - SLL: zero fill.
    - SRL: zero fill.
    - SRA: fill with bit WIDTH-1 of the original operand.
    - ROR: bits leaving LSB enter at MSB.
  - cnt -= s; go to DONE when the new cnt==0.
- DONE:
  - result <= working register on entry; done=1 for exactly this cycle.
  - Next edge returns to IDLE.
- Latency: from the start-accept edge, done is high for cycle ceil(shamt/STEP)+1. shamt=0 gives done on the next cycle with result=operand.
- start while busy (SHIFT or DONE) is ignored and not queued. Back-to-back starts are spaced at least one IDLE cycle apart.
- kill in SHIFT or DONE:
  - Return to IDLE at the next edge.
  - No done pulse; result keeps its previous value.
  - kill in IDLE has no effect.
- Arithmetic: shifts are modulo WIDTH. shamt is always less than WIDTH by width. No sign or overflow flags.
- Outputs are registered/state-decoded only; no combinational path from inputs to outputs.

Test Plan:
1. STEP=1, SRL, operand=0x80000000, shamt=4 -> busy high 5 cycles; done on the 5th cycle after accept; result=0x08000000.
2. STEP=1, SRA 0xFFFF7FFF by 8 -> result 0xFFFFFF7F. SLL 0x3FFFFFFF by 2 -> 0xFFFFFFFC. ROR 0x00000001 by 1 -> 0x80000000.
3. shamt=0, operand=0x12345678, op=SRA -> done 1 cycle after accept, result 0x12345678. A second start asserted while busy is ignored: exactly one done pulse, result unchanged by it.
4. STEP=4, SRA 0x80000000 by 31 -> 8 SHIFT cycles (7×4+3); done on cycle 9; result 0xFFFFFFFF.
5. Abort cases, with SRL 0xF0000000 by 20 in progress and result previously 0xAAAA5555:
   - kill on the 3rd SHIFT cycle -> IDLE next edge; no done; result stays 0xAAAA5555; new start then completes normally.
   - rst_n low in the same operation -> busy/done/result go to 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/mc_shift_unit.sv
// Iterative multi-cycle shifter for the execute stage.
// Handles SLL/SRL/SRA/ROR, STEP bits per cycle, start/busy/done handshake.
module mc_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   operand,
    input  logic               kill,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    localparam logic [SHAMT_W-1:0] STEP_L = SHAMT_W'(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               fill_q, fill_d;

    logic [SHAMT_W-1:0] step_amt;
    logic [WIDTH-1:0]   shifted;

    always_comb begin
        step_amt = (cnt_q < STEP_L) ? cnt_q : STEP_L;
    end

    // Apply up to STEP single-bit shifts; fill_q holds the original sign bit.
    always_comb begin
        shifted = data_q;
        for (int i = 0; i < STEP; i++) begin
            if (SHAMT_W'(i) < step_amt) begin
                case (op_q)
                    OP_SLL:  shifted = {shifted[WIDTH-2:0], 1'b0};
                    OP_SRL:  shifted = {1'b0, shifted[WIDTH-1:1]};
                    OP_SRA:  shifted = {fill_q, shifted[WIDTH-1:1]};
                    default: shifted = {shifted[0], shifted[WIDTH-1:1]};
                endcase
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        fill_d   = fill_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    data_d = operand;
                    op_d   = op;
                    fill_d = operand[WIDTH-1];
                    cnt_d  = shamt;
                    if (shamt == '0) begin
                        result_d = operand;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    data_d = shifted;
                    cnt_d  = cnt_q - step_amt;
                    if (cnt_q == step_amt) begin
                        result_d = shifted;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            fill_q   <= fill_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mc_shift_unit.sv
// Directed plus random bench for mc_shift_unit at STEP=1 and STEP=4.
// Expected results come from plain arithmetic shifts, latency from ceil().
module tb_mc_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        start1, start4;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] operand;
    logic        kill;
    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;

    logic        sel;
    logic        busy_s, done_s;
    logic [31:0] result_s;

    int n_asrt;
    int n_fail;

    mc_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op),
        .shamt(shamt), .operand(operand), .kill(kill),
        .busy(busy1), .done(done1), .result(result1)
    );

    mc_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op),
        .shamt(shamt), .operand(operand), .kill(kill),
        .busy(busy4), .done(done4), .result(result4)
    );

    assign busy_s   = sel ? busy4 : busy1;
    assign done_s   = sel ? done4 : done1;
    assign result_s = sel ? result4 : result1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input int sh,
                                          input logic [31:0] x);
        logic [31:0] r;
        case (o)
            2'b00: r = x << sh;
            2'b10: r = x >> sh;
            2'b11: r = $unsigned($signed(x) >>> sh);
            default: r = (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
        endcase
        return r;
    endfunction

    task automatic run(input logic s, input logic [1:0] o, input int sh,
                       input logic [31:0] x, input string tag);
        logic [31:0] exp;
        int st, lat, c;
        st  = s ? 4 : 1;
        lat = (sh + st - 1) / st + 1;
        exp = model(o, sh, x);
        @(negedge clk);
        sel     = s;
        op      = o;
        shamt   = sh[4:0];
        operand = x;
        if (s) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        c = 1;
        while (!done_s && c < 64) begin
            chk({tag, " busy"}, 32'(busy_s), 32'd1);
            @(negedge clk);
            c++;
        end
        chk({tag, " latency"}, 32'(c), 32'(lat));
        chk({tag, " busy@done"}, 32'(busy_s), 32'd1);
        chk({tag, " result"}, result_s, exp);
        @(negedge clk);
        chk({tag, " done drop"}, 32'(done_s), 32'd0);
        chk({tag, " idle"}, 32'(busy_s), 32'd0);
    endtask

    initial begin
        n_asrt  = 0;
        n_fail  = 0;
        sel     = 1'b0;
        rst_n   = 1'b0;
        start1  = 1'b0;
        start4  = 1'b0;
        op      = 2'b00;
        shamt   = '0;
        operand = '0;
        kill    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy1", 32'(busy1), 32'd0);
        chk("rst done1", 32'(done1), 32'd0);
        chk("rst result1", result1, 32'd0);
        chk("rst busy4", 32'(busy4), 32'd0);
        chk("rst result4", result4, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(1'b0, 2'b10, 4, 32'h8000_0000, "srl4");
        run(1'b0, 2'b11, 8, 32'hFFFF_7FFF, "sra8");
        run(1'b0, 2'b00, 2, 32'h3FFF_FFFF, "sll2");
        run(1'b0, 2'b01, 1, 32'h0000_0001, "ror1");
        run(1'b0, 2'b11, 0, 32'h1234_5678, "sra0");
        run(1'b1, 2'b11, 31, 32'h8000_0000, "s4 sra31");
        run(1'b1, 2'b01, 4, 32'h0000_000F, "s4 ror4");
        run(1'b1, 2'b10, 5, 32'hF000_0000, "s4 srl5");
        run(1'b1, 2'b00, 0, 32'hCAFE_F00D, "s4 sll0");

        // second start while busy is ignored
        @(negedge clk);
        sel = 1'b0; op = 2'b11; shamt = 5'd0; operand = 32'h1234_5678;
        start1 = 1'b1;
        @(negedge clk);
        chk("ign done", 32'(done1), 32'd1);
        chk("ign result", result1, 32'h1234_5678);
        operand = 32'hDEAD_BEEF; shamt = 5'd3;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("ign nodone", 32'(done1), 32'd0);
            chk("ign nobusy", 32'(busy1), 32'd0);
            @(negedge clk);
        end
        chk("ign hold", result1, 32'h1234_5678);

        // start with kill in IDLE captures nothing
        start1 = 1'b1; kill = 1'b1;
        @(negedge clk);
        start1 = 1'b0; kill = 1'b0;
        chk("killstart busy", 32'(busy1), 32'd0);

        // kill on the 3rd SHIFT cycle
        run(1'b0, 2'b10, 0, 32'hAAAA_5555, "preset");
        @(negedge clk);
        sel = 1'b0; op = 2'b10; shamt = 5'd20; operand = 32'hF000_0000;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill busy", 32'(busy1), 32'd0);
        chk("kill done", 32'(done1), 32'd0);
        chk("kill result", result1, 32'hAAAA_5555);
        for (int i = 0; i < 25; i++) begin
            chk("kill nodone", 32'(done1), 32'd0);
            @(negedge clk);
        end
        run(1'b0, 2'b10, 20, 32'hF000_0000, "after kill");

        // asynchronous reset mid-operation
        @(negedge clk);
        sel = 1'b0; op = 2'b10; shamt = 5'd20; operand = 32'hF000_0000;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", 32'(busy1), 32'd0);
        chk("arst done", 32'(done1), 32'd0);
        chk("arst result", result1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 2'b01, 16, 32'h1234_ABCD, "after rst");

        for (int i = 0; i < 40; i++) begin
            run(1'(i % 2), 2'($urandom_range(0, 3)),
                int'($urandom_range(0, 31)), $urandom, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
